// File: rtl/adq_record_ctrl.sv
// Triggered record-acquisition sequencer: arm, qualify trigger, holdoff,
// gate one record of sandbox data onto the LVDS interface, repeat N times.
module adq_record_ctrl #(
    parameter int unsigned RecLenBits  = 16,
    parameter int unsigned HoldoffBits = 16,
    parameter int unsigned NofRecBits  = 16,
    parameter int unsigned MissBits    = 8
) (
    input  logic                   ac_clk1x,
    input  logic                   rst_i,
    input  logic                   arm_i,
    input  logic                   disarm_i,
    input  logic [3:0]             trigger_vector_i,
    input  logic [RecLenBits-1:0]  record_length_i,
    input  logic [HoldoffBits-1:0] holdoff_i,
    input  logic [NofRecBits-1:0]  nof_records_i,
    output logic                   data_dry_o,
    output logic [1:0]             trig_phase_o,
    output logic [NofRecBits-1:0]  records_done_o,
    output logic [MissBits-1:0]    missed_trig_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [2:0]             state_o
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_HOLDOFF = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t                 state;

    // Configuration captured when an arm request is accepted
    logic [RecLenBits-1:0]  len_m1_q;
    logic [HoldoffBits-1:0] holdoff_q;
    logic [NofRecBits-1:0]  nof_q;

    logic [HoldoffBits-1:0] hold_cnt;
    logic [RecLenBits-1:0]  sample_cnt;

    // Decoded events for the current cycle
    logic                   trig_hit;
    logic [1:0]             trig_idx;
    logic                   last_sample;
    logic                   arm_ok;
    logic                   abort;
    logic                   trig_ok;
    logic                   hold_done;
    logic                   start_cap;
    logic                   rec_end;
    logic                   acq_end;
    logic                   miss_ev;
    logic [NofRecBits-1:0]  rec_next;
    logic [MissBits-1:0]    miss_next;

    assign state_o = 3'(state);

    // Lowest set trigger bit selects the phase of the starting sample
    always_comb begin
        trig_hit = |trigger_vector_i;
        trig_idx = 2'd3;
        if (trigger_vector_i[0]) begin
            trig_idx = 2'd0;
        end else if (trigger_vector_i[1]) begin
            trig_idx = 2'd1;
        end else if (trigger_vector_i[2]) begin
            trig_idx = 2'd2;
        end
    end

    // Event decode; disarm outranks triggers and end-of-record
    always_comb begin
        last_sample = (sample_cnt == len_m1_q);
        rec_next    = records_done_o + NofRecBits'(1);
        miss_next   = (&missed_trig_o) ? missed_trig_o : missed_trig_o + MissBits'(1);
        arm_ok      = (state == ST_IDLE) && arm_i && !disarm_i;
        abort       = (state != ST_IDLE) && disarm_i;
        trig_ok     = (state == ST_ARMED) && trig_hit && !disarm_i;
        hold_done   = (state == ST_HOLDOFF) && (hold_cnt == '0) && !disarm_i;
        start_cap   = (trig_ok && (holdoff_q == '0)) || hold_done;
        rec_end     = (state == ST_CAPTURE) && last_sample && !disarm_i;
        acq_end     = rec_end && (nof_q != '0) && (rec_next == nof_q);
        // A trigger on the final sample is not counted: a held trigger
        // carries into the following ARMED cycle and is accepted there.
        miss_ev     = trig_hit && !disarm_i &&
                      ((state == ST_HOLDOFF) ||
                       ((state == ST_CAPTURE) && !last_sample));
    end

    // Sequencer state and the strobes that follow it
    always_ff @(posedge ac_clk1x) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            data_dry_o <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else if (abort) begin
            state      <= ST_IDLE;
            data_dry_o <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arm_ok) begin
                        state  <= ST_ARMED;
                        busy_o <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (start_cap) begin
                        state      <= ST_CAPTURE;
                        data_dry_o <= 1'b1;
                    end else if (trig_ok) begin
                        state <= ST_HOLDOFF;
                    end
                end
                ST_HOLDOFF: begin
                    if (start_cap) begin
                        state      <= ST_CAPTURE;
                        data_dry_o <= 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    if (acq_end) begin
                        state      <= ST_DONE;
                        data_dry_o <= 1'b0;
                        done_o     <= 1'b1;
                    end else if (rec_end) begin
                        state      <= ST_ARMED;
                        data_dry_o <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                end
                default: begin
                    state      <= ST_IDLE;
                    data_dry_o <= 1'b0;
                    busy_o     <= 1'b0;
                    done_o     <= 1'b0;
                end
            endcase
        end
    end

    // Latch configuration on an accepted arm; zero length means one sample
    always_ff @(posedge ac_clk1x) begin
        if (rst_i) begin
            len_m1_q  <= '0;
            holdoff_q <= '0;
            nof_q     <= '0;
        end else if (arm_ok) begin
            len_m1_q  <= (record_length_i == '0) ? '0
                         : record_length_i - RecLenBits'(1);
            holdoff_q <= holdoff_i;
            nof_q     <= nof_records_i;
        end
    end

    // Holdoff countdown, loaded with holdoff-1 on trigger acceptance
    always_ff @(posedge ac_clk1x) begin
        if (rst_i) begin
            hold_cnt <= '0;
        end else if (trig_ok) begin
            hold_cnt <= holdoff_q - HoldoffBits'(1);
        end else if ((state == ST_HOLDOFF) && (hold_cnt != '0)) begin
            hold_cnt <= hold_cnt - HoldoffBits'(1);
        end
    end

    // In-record sample counter, 0..len-1
    always_ff @(posedge ac_clk1x) begin
        if (rst_i) begin
            sample_cnt <= '0;
        end else if (start_cap) begin
            sample_cnt <= '0;
        end else if ((state == ST_CAPTURE) && !last_sample) begin
            sample_cnt <= sample_cnt + RecLenBits'(1);
        end
    end

    // Phase of the trigger that started the current record
    always_ff @(posedge ac_clk1x) begin
        if (rst_i) begin
            trig_phase_o <= 2'd0;
        end else if (trig_ok) begin
            trig_phase_o <= trig_idx;
        end
    end

    // Completed-record count, cleared on arm, wraps when unlimited
    always_ff @(posedge ac_clk1x) begin
        if (rst_i) begin
            records_done_o <= '0;
        end else if (arm_ok) begin
            records_done_o <= '0;
        end else if (rec_end) begin
            records_done_o <= rec_next;
        end
    end

    // Saturating count of triggers ignored during holdoff/capture
    always_ff @(posedge ac_clk1x) begin
        if (rst_i) begin
            missed_trig_o <= '0;
        end else if (arm_ok) begin
            missed_trig_o <= '0;
        end else if (miss_ev) begin
            missed_trig_o <= miss_next;
        end
    end

endmodule

// File: tb/tb_adq_record_ctrl.sv
// Bench for adq_record_ctrl: table of single-record vectors plus
// hand-written multi-record, saturation, abort and reset sequences.
module tb_adq_record_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        arm;
    logic        disarm;
    logic [3:0]  trig;
    logic [15:0] rec_len;
    logic [15:0] holdoff;
    logic [15:0] nof_rec;
    logic        data_dry;
    logic [1:0]  trig_phase;
    logic [15:0] records_done;
    logic [7:0]  missed_trig;
    logic        busy;
    logic        done;
    logic [2:0]  state;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] len;
        logic [15:0] hold;
        logic [3:0]  trig;
        bit          scramble;
        logic [1:0]  exp_phase;
    } vec_t;

    typedef logic [2:0] obs_t; // {data_dry, busy, done}

    vec_t vecs[5];
    obs_t exp_q[$];

    always #5 clk = ~clk;

    adq_record_ctrl #(
        .RecLenBits (16),
        .HoldoffBits(16),
        .NofRecBits (16),
        .MissBits   (8)
    ) dut (
        .ac_clk1x        (clk),
        .rst_i           (rst),
        .arm_i           (arm),
        .disarm_i        (disarm),
        .trigger_vector_i(trig),
        .record_length_i (rec_len),
        .holdoff_i       (holdoff),
        .nof_records_i   (nof_rec),
        .data_dry_o      (data_dry),
        .trig_phase_o    (trig_phase),
        .records_done_o  (records_done),
        .missed_trig_o   (missed_trig),
        .busy_o          (busy),
        .done_o          (done),
        .state_o         (state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One cycle: wait for the sample point and compare against the scoreboard
    task automatic drain(input string name);
        obs_t e;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check({name, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check(name, 32'({data_dry, busy, done}), 32'(e));
        end
    endtask

    task automatic arm_with(input logic [15:0] l, input logic [15:0] h, input logic [15:0] n);
        @(negedge clk);
        rec_len = l;
        holdoff = h;
        nof_rec = n;
        arm     = 1'b1;
        @(negedge clk);
        arm     = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int l_eff;
        int h;
        arm_with(v.len, v.hold, 16'd1);
        check("arm_state", 32'(state), 32'd1);
        check("arm_busy", 32'(busy), 32'd1);
        trig = v.trig;
        if (v.scramble) begin
            rec_len = 16'd7;
            holdoff = 16'd3;
            nof_rec = 16'd2;
        end
        l_eff = (v.len == 16'd0) ? 1 : int'(v.len);
        h     = int'(v.hold);
        for (int k = 0; k <= h + l_eff + 1; k++) begin
            exp_q.push_back({(k >= h) && (k < h + l_eff), k <= h + l_eff, k == h + l_eff});
        end
        for (int k = 0; k <= h + l_eff + 1; k++) begin
            drain("vec_timeline");
            trig = 4'd0;
        end
        check("vec_phase", 32'(trig_phase), 32'(v.exp_phase));
        check("vec_records", 32'(records_done), 32'd1);
        check("vec_missed", 32'(missed_trig), 32'd0);
        check("vec_state_idle", 32'(state), 32'd0);
    endtask

    initial begin
        bit done_seen;

        vecs[0] = '{len: 16'd8, hold: 16'd0, trig: 4'b0100, scramble: 1'b0, exp_phase: 2'd2};
        vecs[1] = '{len: 16'd4, hold: 16'd5, trig: 4'b0001, scramble: 1'b1, exp_phase: 2'd0};
        vecs[2] = '{len: 16'd0, hold: 16'd0, trig: 4'b0110, scramble: 1'b0, exp_phase: 2'd1};
        vecs[3] = '{len: 16'd3, hold: 16'd2, trig: 4'b1000, scramble: 1'b1, exp_phase: 2'd3};
        vecs[4] = '{len: 16'd1, hold: 16'd1, trig: 4'b1010, scramble: 1'b0, exp_phase: 2'd1};

        rst     = 1'b1;
        arm     = 1'b0;
        disarm  = 1'b0;
        trig    = 4'd0;
        rec_len = 16'd0;
        holdoff = 16'd0;
        nof_rec = 16'd0;
        repeat (2) @(negedge clk);
        check("reset_outputs",
              32'({data_dry, busy, done, trig_phase, state}), 32'd0);
        check("reset_counters", 32'({records_done, missed_trig}), 32'd0);
        rst = 1'b0;

        // Single-record vectors
        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i]);
        end

        // Three records with a constantly held trigger; a stray arm is ignored
        arm_with(16'd10, 16'd0, 16'd3);
        trig = 4'b1111;
        for (int k = 0; k <= 34; k++) begin
            exp_q.push_back({(k % 11 < 10) && (k < 33), k <= 32, k == 32});
        end
        for (int k = 0; k <= 34; k++) begin
            drain("multi_timeline");
            arm = (k == 15);
            if (k == 32) trig = 4'd0;
        end
        arm = 1'b0;
        check("multi_missed", 32'(missed_trig), 32'd27);
        check("multi_records", 32'(records_done), 32'd3);
        check("multi_phase", 32'(trig_phase), 32'd0);
        check("multi_state", 32'(state), 32'd0);

        // Unlimited records and missed-trigger saturation
        arm_with(16'd400, 16'd0, 16'd0);
        trig = 4'b0100;
        done_seen = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
        end
        check("sat_missed", 32'(missed_trig), 32'd255);
        check("sat_state_capture", 32'(state), 32'd3);
        check("sat_dry", 32'(data_dry), 32'd1);
        trig = 4'd0;
        repeat (120) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
        end
        check("unlim_records", 32'(records_done), 32'd1);
        check("unlim_state_armed", 32'(state), 32'd1);
        check("unlim_no_done", 32'(done_seen), 32'd0);
        disarm = 1'b1;
        @(negedge clk);
        disarm = 1'b0;
        check("unlim_abort_state", 32'({state, busy, data_dry, done}), 32'd0);
        check("unlim_abort_counts", 32'({records_done, missed_trig}), {16'd1, 8'd255});

        // Abort in the third sample of a 16-sample record
        arm_with(16'd16, 16'd0, 16'd1);
        check("rearm_clears", 32'({records_done, missed_trig}), 32'd0);
        trig = 4'b0010;
        repeat (3) @(negedge clk);
        check("abort_pre_dry", 32'(data_dry), 32'd1);
        disarm = 1'b1;
        @(negedge clk);
        disarm = 1'b0;
        trig   = 4'd0;
        check("abort_outputs", 32'({state, busy, data_dry, done}), 32'd0);
        check("abort_records", 32'(records_done), 32'd0);
        check("abort_missed", 32'(missed_trig), 32'd2);
        check("abort_phase", 32'(trig_phase), 32'd1);
        done_seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
        end
        check("abort_no_done", 32'(done_seen), 32'd0);

        // Arm and disarm together in IDLE: stay idle, counters kept
        @(negedge clk);
        arm    = 1'b1;
        disarm = 1'b1;
        @(negedge clk);
        arm    = 1'b0;
        disarm = 1'b0;
        check("arm_disarm_idle", 32'({state, busy}), 32'd0);
        check("arm_disarm_missed", 32'(missed_trig), 32'd2);

        // Reset asserted during HOLDOFF
        arm_with(16'd4, 16'd10, 16'd1);
        trig = 4'b1000;
        @(negedge clk);
        trig = 4'd0;
        @(negedge clk);
        check("hold_state", 32'(state), 32'd2);
        check("hold_phase", 32'(trig_phase), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_hold_outputs",
              32'({data_dry, busy, done, trig_phase, state}), 32'd0);
        check("rst_hold_counters", 32'({records_done, missed_trig}), 32'd0);
        done_seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (data_dry || done || busy) done_seen = 1'b1;
        end
        check("rst_hold_quiet", 32'(done_seen), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adq_record_ctrl.md
Name: adq_record_ctrl

Overview:
Triggered record-acquisition sequencer in the ADQ2xx sandbox, clocked by ac_clk1x.
- Arms on command from the SPI register file.
- Qualifies the 4-phase trigger vector from the communication FPGA.
- Applies a programmable holdoff, then asserts the data-ready strobe that gates sandbox data onto the LVDS output interface for exactly one record length.
- Repeats for a programmed number of records and reports status and missed-trigger statistics.

Parameters:
RecLenBits, 16, width of record length and in-record sample counter
HoldoffBits, 16, width of holdoff count
NofRecBits, 16, width of record count and completed-record counter
MissBits, 8, width of saturating missed-trigger counter

Ports:
ac_clk1x  in  1  clock; sole clock of the block
rst_i  in  1  synchronous active-high reset
arm_i  in  1  one-cycle arm request from SPI register file
disarm_i  in  1  one-cycle abort request
trigger_vector_i  in  4  per-phase trigger flags; bit k = trigger on sample phase k
record_length_i  in  RecLenBits  samples (ac_clk1x cycles) per record
holdoff_i  in  HoldoffBits  cycles between trigger and record start
nof_records_i  in  NofRecBits  records per acquisition; 0 = unlimited
data_dry_o  out  1  data-ready strobe to LVDS output interface
trig_phase_o  out  2  phase index of the trigger that started the current record
records_done_o  out  NofRecBits  completed records in current acquisition
missed_trig_o  out  MissBits  triggers ignored while in HOLDOFF/CAPTURE, saturating
busy_o  out  1  high in any state except IDLE
done_o  out  1  one-cycle pulse when acquisition completes
state_o  out  3  current state encoding, for SPI readback

Behaviour:
Reset and output timing:
- All outputs registered.
- Reset: state IDLE (0); data_dry_o, busy_o and done_o = 0; trig_phase_o, records_done_o and missed_trig_o = 0.
- Reset overrides every other input in the same cycle.
- Reset mid-record drops data_dry_o on the next edge; no done_o pulse.

State encoding:
- IDLE=0, ARMED=1, HOLDOFF=2, CAPTURE=3, DONE=4.

Arming and config latching:
- record_length_i, holdoff_i and nof_records_i are latched on the arm_i edge accepted in IDLE.
- Later input changes are ignored until the next arm.
- A record_length of 0 is treated as 1.

IDLE:
- arm_i -> ARMED.
- On the same edge, clear records_done_o and missed_trig_o.
- arm_i in any other state is ignored.

ARMED:
- Trigger qualification: trigger_vector_i != 0.
- On a trigger, latch trig_phase_o = index of the lowest set bit (4'b0110 -> 1).
- If latched holdoff == 0 -> CAPTURE; else -> HOLDOFF with the counter loaded to holdoff-1.

HOLDOFF:
- Counter decrements each cycle; at 0 -> CAPTURE.
- Time in HOLDOFF is exactly holdoff cycles.

CAPTURE:
- data_dry_o is high for every cycle in CAPTURE, exactly record_length cycles.
- Sample counter runs 0..len-1.
- On the last sample, records_done_o increments (wraps at 2^NofRecBits when unlimited).
- Next state: if nof_records != 0 and the new count == nof_records -> DONE; else -> ARMED.

Trigger timing and missed triggers:
- With holdoff 0, a trigger sampled at edge T gives data_dry_o high from edge T+1.
- With holdoff H > 0, data_dry_o is high from edge T+1+H.
- Back-to-back records have at least one ARMED cycle with data_dry_o = 0 between them.
- A trigger present while in HOLDOFF or CAPTURE increments missed_trig_o, saturating at all-ones.
- A trigger present in the ARMED cycle immediately after CAPTURE is accepted normally.

DONE:
- done_o = 1 for one cycle, then -> IDLE.
- busy_o = 0 from IDLE onward.

Abort:
- disarm_i from any non-IDLE state -> IDLE next edge.
- data_dry_o = 0 from that edge; records_done_o and missed_trig_o hold their values; no done_o pulse.
- disarm_i has priority over a trigger or end-of-record in the same cycle.
- disarm_i in IDLE has no effect.
- arm_i and disarm_i together in IDLE: disarm_i wins, stay IDLE.

Test Plan:
1. Basic record: reset, record_length=8, holdoff=0, nof_records=1; arm; trigger_vector=4'b0100 at edge T -> data_dry_o high edges T+1..T+8, trig_phase_o=2, records_done_o=1, done_o pulse at T+9, busy_o=0 at T+10.
2. Holdoff: holdoff=5, length=4; trigger at T -> data_dry_o high T+6..T+9 exactly.
3. Multi-record and missed triggers: nof_records=3, length=10; trigger held constantly high -> three 10-cycle data_dry_o bursts separated by one low cycle; missed_trig_o=27 (9 in-record triggers per record); records_done_o=3; single done_o.
4. Unlimited and saturation: nof_records=0, MissBits=8; 300 triggers during CAPTURE of a long record -> missed_trig_o=255; acquisition never reaches DONE until disarm_i.
5. Abort: disarm_i in cycle 3 of a 16-sample record -> data_dry_o=0 next edge, state_o=0, no done_o, records_done_o unchanged; new arm_i clears counters.
6. Corner cases: record_length=0 -> 1-cycle data_dry_o; config inputs changed mid-acquisition -> no effect; rst_i asserted during HOLDOFF -> all outputs at reset values next edge.
